// File: rtl/encoder_8b10b.sv
// encoder_8b10b: 8b/10b line encoder (IEEE 802.3 / JESD204B conventions).
// Input byte is HGFEDCBA. The output symbol is abcdeifghj, with bit 9 = a,
// which is transmitted first. Running disparity is tracked across symbols.
// There is a one-deep output register with a ready/valid handshake on both
// sides, so the encoder can sustain one symbol per clock.
// Optional feature macro: ENCODER_8B10B_K_CHECK_EN
//   When it is defined, an unsupported K byte raises k_err and is sent as K.28.5.
//   When it is undefined, k_err is tied low and an unsupported K byte is sent
//   as its D.x.y equivalent.
module encoder_8b10b (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_k,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out_symbol,
    output logic       out_rd,
    output logic       k_err
);

    // 5b/6b code (abcdei) for the RD- column. The RD+ column is the bitwise
    // complement for every unbalanced code and for D.7.
    function automatic logic [5:0] enc6_rdm(input logic [4:0] x);
        logic [5:0] c;
        c = 6'b000000;
        case (x)
            5'd0:  c = 6'b100111;
            5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;
            5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;
            5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;
            5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;
            5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;
            5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;
            5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;
            5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;
            5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;
            5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;
            5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;
            5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;
            5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;
            5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;
            5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;
            5'd31: c = 6'b101011;
        endcase
        return c;
    endfunction

    // 3b/4b data code (fghj) for intermediate RD-. y = 7 gives the primary P7
    // code; the alternate A7 code is selected separately.
    function automatic logic [3:0] enc4_d_rdm(input logic [2:0] y);
        logic [3:0] c;
        c = 4'b0000;
        case (y)
            3'd0: c = 4'b1011;
            3'd1: c = 4'b1001;
            3'd2: c = 4'b0101;
            3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;
            3'd5: c = 4'b1010;
            3'd6: c = 4'b0110;
            3'd7: c = 4'b1110;
        endcase
        return c;
    endfunction

    // 3b/4b control code (fghj) for intermediate RD-. Every entry is
    // complemented when the intermediate RD is RD+.
    function automatic logic [3:0] enc4_k_rdm(input logic [2:0] y);
        logic [3:0] c;
        c = 4'b0000;
        case (y)
            3'd0: c = 4'b1011;
            3'd1: c = 4'b0110;
            3'd2: c = 4'b1010;
            3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;
            3'd5: c = 4'b0101;
            3'd6: c = 4'b1001;
            3'd7: c = 4'b0111;
        endcase
        return c;
    endfunction

    function automatic logic balanced6(input logic [5:0] c);
        return ($countones(c) == 3);
    endfunction

    function automatic logic balanced4(input logic [3:0] c);
        return ($countones(c) == 2);
    endfunction

    // Supported K set: K.28.0-7, K.23.7, K.27.7, K.29.7 and K.30.7.
    function automatic logic k_supported(input logic [7:0] b);
        return (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) ||
               (b == 8'hFD) || (b == 8'hFE);
    endfunction

    logic       rd_q;
    logic       out_valid_q;
    logic [9:0] out_symbol_q;

    logic       accept;
    logic [7:0] enc_byte;
    logic       enc_k;
    logic       kerr_d;
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] base6;
    logic [5:0] code6;
    logic       rd_mid;
    logic       use_a7;
    logic [3:0] base4;
    logic       comp4;
    logic [3:0] code4;
    logic       rd_d;
    logic [9:0] symbol_d;

    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign out_symbol = out_symbol_q;
    assign out_rd     = rd_q;

    // Choose the character that is actually encoded, applying the policy for unsupported K codes.
    always_comb begin
        enc_byte = in_data;
        enc_k    = in_k;
        kerr_d   = 1'b0;
`ifdef ENCODER_8B10B_K_CHECK_EN
        if (in_k && !k_supported(in_data)) begin
            enc_byte = 8'hBC;
            kerr_d   = 1'b1;
        end
`else
        enc_k    = in_k && k_supported(in_data);
`endif
    end

    // 5b/6b sub-block: encode EDCBA against the current RD and derive the intermediate RD.
    always_comb begin
        x = enc_byte[4:0];
        // K.28 has its own 6b code; K.23/27/29/30 share the D.x 6b codes.
        base6 = (enc_k && (x == 5'd28)) ? 6'b001111 : enc6_rdm(x);
        if (rd_q && (!balanced6(base6) || (x == 5'd7)))
            code6 = ~base6;
        else
            code6 = base6;
        rd_mid = balanced6(code6) ? rd_q : !rd_q;
    end

    // 3b/4b sub-block: encode HGF against the intermediate RD and derive the final RD.
    always_comb begin
        y = enc_byte[7:5];
        // A7 avoids a run of five equal bits across the 6b/4b boundary.
        use_a7 = (y == 3'd7) &&
                 ((!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                  ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
        if (enc_k) begin
            base4 = enc4_k_rdm(y);
            comp4 = rd_mid;
        end else if (use_a7) begin
            base4 = 4'b0111;
            comp4 = rd_mid;
        end else begin
            base4 = enc4_d_rdm(y);
            // D.x.3 is balanced but still has distinct codes for each RD.
            comp4 = rd_mid && (!balanced4(base4) || (y == 3'd3));
        end
        code4    = comp4 ? ~base4 : base4;
        rd_d     = balanced4(code4) ? rd_mid : !rd_mid;
        symbol_d = {code6, code4};
    end

    // Output register and running disparity: load on accept, clear valid on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_symbol_q <= 10'h000;
            rd_q         <= 1'b0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            out_symbol_q <= symbol_d;
            rd_q         <= rd_d;
        end else if (out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

`ifdef ENCODER_8B10B_K_CHECK_EN
    logic k_err_q;

    // Error flag travels with the symbol it belongs to.
    always_ff @(posedge clk) begin
        if (rst)
            k_err_q <= 1'b0;
        else if (accept)
            k_err_q <= kerr_d;
    end

    assign k_err = k_err_q;
`else
    assign k_err = 1'b0;

    logic unused_kerr;
    assign unused_kerr = kerr_d;
`endif

endmodule

// File: tb/tb_encoder_8b10b.sv
// Testbench for encoder_8b10b. Expected symbols are hand-derived from the
// standard 8b/10b tables and queued when stimulus is driven. They are
// popped and compared when the DUT presents the symbol.
module tb_encoder_8b10b;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_k;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_symbol;
    logic       out_rd;
    logic       k_err;

    typedef struct packed {
        logic [9:0] sym;
        logic       rd;
        logic       kerr;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Tables: {byte, k, expected symbol, expected RD after the symbol}
    logic [7:0] dis_d [7];
    logic       dis_k [7];
    logic [9:0] dis_s [7];
    logic       dis_r [7];
    logic [7:0] kc_d  [7];
    logic [9:0] kc_s  [7];
    logic       kc_r  [7];
    logic [7:0] bb_d  [8];
    logic       bb_k  [8];
    logic [9:0] bb_s  [8];
    logic       bb_r  [8];

    encoder_8b10b dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_k       (in_k),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_symbol (out_symbol),
        .out_rd     (out_rd),
        .k_err      (k_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Presents one symbol for one accepting edge and queues its expected result.
    task automatic drive_one(input logic [7:0] d, input logic k,
                             input logic [9:0] es, input logic er, input logic ek);
        exp_t e;
        e.sym = es; e.rd = er; e.kerr = ek;
        in_valid = 1'b1; in_data = d; in_k = k;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_k     = 1'($urandom);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hBC; in_k = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_assert++; if (out_symbol !== 10'h000) begin n_fail++; $display("FAIL reset out_symbol: got %h want 000", out_symbol); end
        n_assert++; if (out_rd !== 1'b0) begin n_fail++; $display("FAIL reset out_rd: got %b want 0", out_rd); end
        n_assert++; if (k_err !== 1'b0) begin n_fail++; $display("FAIL reset k_err: got %b want 0", k_err); end
        n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_d0;
        exp_t e;
        drive_one(8'h00, 1'b0, 10'h274, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL d0 valid: got %b want 1", out_valid); end
        n_assert++; if (out_symbol !== e.sym) begin n_fail++; $display("FAIL d0 symbol: got %h want %h", out_symbol, e.sym); end
        n_assert++; if (out_rd !== e.rd) begin n_fail++; $display("FAIL d0 rd: got %b want %b", out_rd, e.rd); end
        n_assert++; if (k_err !== e.kerr) begin n_fail++; $display("FAIL d0 k_err: got %b want %b", k_err, e.kerr); end
    endtask

    task automatic test_disparity;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            drive_one(dis_d[i], dis_k[i], dis_s[i], dis_r[i], 1'b0);
            e = exp_q.pop_front();
            n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL disparity[%0d] valid: got %b want 1", i, out_valid); end
            n_assert++; if (out_symbol !== e.sym) begin n_fail++; $display("FAIL disparity[%0d] symbol: got %h want %h", i, out_symbol, e.sym); end
            n_assert++; if (out_rd !== e.rd) begin n_fail++; $display("FAIL disparity[%0d] rd: got %b want %b", i, out_rd, e.rd); end
        end
    endtask

    task automatic test_k_codes;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            drive_one(kc_d[i], 1'b1, kc_s[i], kc_r[i], 1'b0);
            e = exp_q.pop_front();
            n_assert++; if (out_symbol !== e.sym) begin n_fail++; $display("FAIL kcode[%0d] symbol: got %h want %h", i, out_symbol, e.sym); end
            n_assert++; if (out_rd !== e.rd) begin n_fail++; $display("FAIL kcode[%0d] rd: got %b want %b", i, out_rd, e.rd); end
            n_assert++; if (k_err !== e.kerr) begin n_fail++; $display("FAIL kcode[%0d] k_err: got %b want %b", i, out_rd, e.kerr); end
        end
    endtask

    task automatic test_idle;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0; in_data = 8'($urandom); in_k = 1'($urandom);
            @(posedge clk); #1;
            n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle[%0d] out_valid: got %b want 0", i, out_valid); end
        end
        n_assert++; if (out_rd !== 1'b0) begin n_fail++; $display("FAIL idle rd: got %b want 0", out_rd); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int sent = 0;
        int got  = 0;
        logic [9:0] held_sym;
        logic held_rd;
        logic prev_stall;
        logic stall;
        held_sym = 10'h000; held_rd = 1'b0; prev_stall = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            stall = (cyc >= 4) && (cyc < 7);
            out_ready = !stall;
            if (sent < 8) begin
                in_valid = 1'b1; in_data = bb_d[sent]; in_k = bb_k[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_assert++; n_fail++;
                    $display("FAIL b2b unexpected output: got %h want none", out_symbol);
                end else if (!stall) begin
                    e = exp_q.pop_front();
                    got++;
                    n_assert++; if (out_symbol !== e.sym) begin n_fail++; $display("FAIL b2b[%0d] symbol: got %h want %h", got - 1, out_symbol, e.sym); end
                    n_assert++; if (out_rd !== e.rd) begin n_fail++; $display("FAIL b2b[%0d] rd: got %b want %b", got - 1, out_rd, e.rd); end
                end else begin
                    n_assert++; if (out_symbol !== exp_q[0].sym) begin n_fail++; $display("FAIL b2b stall symbol: got %h want %h", out_symbol, exp_q[0].sym); end
                    n_assert++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b stall in_ready: got %b want 0", in_ready); end
                    if (prev_stall) begin
                        n_assert++; if (out_symbol !== held_sym || out_rd !== held_rd) begin n_fail++; $display("FAIL b2b stall hold: got %h/%b want %h/%b", out_symbol, out_rd, held_sym, held_rd); end
                    end
                end
            end
            held_sym = out_symbol; held_rd = out_rd; prev_stall = stall;
            if (in_valid && in_ready) begin
                e.sym = bb_s[sent]; e.rd = bb_r[sent]; e.kerr = 1'b0;
                exp_q.push_back(e);
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_assert++; if (got != 8 || sent != 8) begin n_fail++; $display("FAIL b2b count: got %0d/%0d want 8/8", got, sent); end
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b drained: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midstream;
        exp_t e;
        drive_one(8'hBC, 1'b1, 10'h0FA, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_assert++; if (out_symbol !== e.sym || out_rd !== e.rd) begin n_fail++; $display("FAIL midrst pre symbol: got %h/%b want %h/%b", out_symbol, out_rd, e.sym, e.rd); end
        out_ready = 1'b0; rst = 1'b1;
        in_valid = 1'b1; in_data = 8'hB5; in_k = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst out_valid: got %b want 0", out_valid); end
        n_assert++; if (out_rd !== 1'b0) begin n_fail++; $display("FAIL midrst out_rd: got %b want 0", out_rd); end
        drive_one(8'h00, 1'b0, 10'h274, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst post valid: got %b want 1", out_valid); end
        n_assert++; if (out_symbol !== e.sym) begin n_fail++; $display("FAIL midrst post symbol: got %h want %h", out_symbol, e.sym); end
        n_assert++; if (out_rd !== e.rd) begin n_fail++; $display("FAIL midrst post rd: got %b want %b", out_rd, e.rd); end
    endtask

    task automatic test_k_err;
        exp_t e;
        logic [7:0] kd [3];
        logic [9:0] ks [3];
        logic       kr [3];
        logic       ke [3];
        kd[0] = 8'h00; kd[1] = 8'h55; kd[2] = 8'hBC;
`ifdef ENCODER_8B10B_K_CHECK_EN
        ks[0] = 10'h0FA; kr[0] = 1'b1; ke[0] = 1'b1;
        ks[1] = 10'h305; kr[1] = 1'b0; ke[1] = 1'b1;
`else
        ks[0] = 10'h274; kr[0] = 1'b0; ke[0] = 1'b0;
        ks[1] = 10'h2A5; kr[1] = 1'b0; ke[1] = 1'b0;
`endif
        ks[2] = 10'h0FA; kr[2] = 1'b1; ke[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_one(kd[i], 1'b1, ks[i], kr[i], ke[i]);
            e = exp_q.pop_front();
            n_assert++; if (out_symbol !== e.sym) begin n_fail++; $display("FAIL kerr[%0d] symbol: got %h want %h", i, out_symbol, e.sym); end
            n_assert++; if (out_rd !== e.rd) begin n_fail++; $display("FAIL kerr[%0d] rd: got %b want %b", i, out_rd, e.rd); end
            n_assert++; if (k_err !== e.kerr) begin n_fail++; $display("FAIL kerr[%0d] k_err: got %b want %b", i, k_err, e.kerr); end
        end
    endtask

    initial begin
        // RD sequence starting from RD-
        dis_d = '{8'hBC, 8'hB5, 8'hBC, 8'hB5, 8'hF1, 8'h00, 8'hEB};
        dis_k = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        dis_s = '{10'h0FA, 10'h2AA, 10'h305, 10'h2AA, 10'h237, 10'h18B, 10'h348};
        dis_r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        // K.23.7, K.28.7, K.27.7, K.28.0, K.28.1, K.29.7, K.28.5 starting from RD-
        kc_d  = '{8'hF7, 8'hFC, 8'hFB, 8'h1C, 8'h3C, 8'hFD, 8'hBC};
        kc_s  = '{10'h3A8, 10'h0F8, 10'h368, 10'h0F4, 10'h0F9, 10'h117, 10'h305};
        kc_r  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        // Streaming sequence starting from RD-
        bb_d  = '{8'hBC, 8'hB5, 8'hBC, 8'h00, 8'hF1, 8'h00, 8'h4A, 8'hEB};
        bb_k  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        bb_s  = '{10'h0FA, 10'h2AA, 10'h305, 10'h274, 10'h237, 10'h18B, 10'h155, 10'h348};
        bb_r  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_k = 1'b0; out_ready = 1'b1;
        test_reset();
        test_d0();
        test_disparity();
        test_k_codes();
        test_idle();
        test_back_to_back();
        test_reset_midstream();
        test_k_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
